// File: rtl/seq_core_pkg.sv
// seq_core_pkg: shared definitions for the seq_core_ctrl sequencer.
//   - opcode encodings (OP_*)
//   - FSM state encoding (state_t)
//   - instruction field positions and widths
// Instruction word: [15:12] opcode, [9:8] dst, [5:4] srcA, [1:0] srcB, [7:0] imm.
package seq_core_pkg;

  localparam int INSTR_W     = 16;
  localparam int OPC_W       = 4;
  localparam int OPC_LSB     = 12;
  localparam int DST_LSB     = 8;
  localparam int SRCA_LSB    = 4;
  localparam int SRCB_LSB    = 0;
  localparam int REG_FIELD_W = 2;
  localparam int IMM_LSB     = 0;
  localparam int IMM_W       = 8;

  localparam logic [OPC_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'b0001;
  localparam logic [OPC_W-1:0] OP_LOAD = 4'b1000;
  localparam logic [OPC_W-1:0] OP_INC  = 4'b1010;
  localparam logic [OPC_W-1:0] OP_DEC  = 4'b1011;
  localparam logic [OPC_W-1:0] OP_HLT  = 4'b1100;
  localparam logic [OPC_W-1:0] OP_JZ   = 4'b1101;
  localparam logic [OPC_W-1:0] OP_JC   = 4'b1110;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'b1111;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WB    = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/seq_core_ctrl_if.sv
// seq_core_ctrl_if: instruction-memory fetch handshake.
//   addr  : fetch address (sequencer -> memory)
//   req   : fetch request (sequencer -> memory)
//   valid : data valid, only meaningful while req is high (memory -> sequencer)
//   data  : 16-bit instruction word (memory -> sequencer)
// Modports: master (sequencer side), slave (memory side).
interface seq_core_ctrl_if #(
  parameter int PC_W = 8
);
  logic [PC_W-1:0] addr;
  logic            req;
  logic            valid;
  logic [15:0]     data;

  modport master (output addr, output req, input valid, input data);
  modport slave  (input addr, input req, output valid, output data);
endinterface

// File: rtl/seq_regfile.sv
// seq_regfile: NREG x DATA_W register file.
//   clk, rst_n        : clock, asynchronous active-low clear of all registers
//   we, waddr, wdata  : single synchronous write port
//   raddr_a / rdata_a : async read port A (operand A)
//   raddr_b / rdata_b : async read port B (operand B)
//   raddr_d / rdata_d : async read port for debug
module seq_regfile #(
  parameter int DATA_W = 8,
  parameter int NREG   = 4,
  parameter int AW     = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  input  logic [AW-1:0]     raddr_b,
  input  logic [AW-1:0]     raddr_d,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] rdata_d
);

  logic [DATA_W-1:0] regs_q [NREG];

  // Reset wins over a same-cycle write, so an aborted write-back never lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];
  assign rdata_d = regs_q[raddr_d];

endmodule

// File: rtl/seq_core_ctrl.sv
// seq_core_ctrl: fetch/decode/execute sequencer with register file and ALU.
//   clk, rst_n  : clock, asynchronous active-low reset
//   imem        : fetch handshake (master modport of seq_core_ctrl_if)
//   retire      : one-cycle pulse per completed instruction
//   halted      : high while in HALT
//   flag_z/c    : zero and carry/borrow flags
//   dbg_raddr   : debug register select; dbg_rdata is its async read
// Optional build macro COND_BRANCH_EN adds JZ (1101) and JC (1110);
// without it those opcodes behave as NOP.
// FSM: FETCH -> EXEC -> (WB ->) FETCH, or EXEC -> HALT.
module seq_core_ctrl
  import seq_core_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int NREG   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_core_ctrl_if.master   imem,
  output logic              retire,
  output logic              halted,
  output logic              flag_z,
  output logic              flag_c,
  input  logic [1:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d, pc_inc, imm_pc;
  logic [INSTR_W-1:0]  ir_p0;
  logic [DATA_W-1:0]   res_p1, res_d;
  logic                c_p1, c_d;
  logic                setf_p1, setf_d;
  logic                flag_z_q, flag_z_d, flag_c_q, flag_c_d;
  logic                retire_q, retire_d;
  logic                ld_ir, ld_res, fetch_ok, rf_we;
  logic [OPC_W-1:0]    opcode;
  logic [AW-1:0]       dst, src_a, src_b, rd_a_sel;
  logic [IMM_W-1:0]    imm;
  logic [DATA_W-1:0]   rd_a, rd_b;
  logic [DATA_W:0]     alu_out;
  logic                unused_ir;

  // Carry/borrow comes out of bit DATA_W of the zero-extended operation;
  // for subtraction that bit is set exactly when a < b.
  function automatic logic [DATA_W:0] alu(input logic [OPC_W-1:0] op,
                                          input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b);
    logic [DATA_W:0] ax, bx, one;
    ax  = {1'b0, a};
    bx  = {1'b0, b};
    one = {{DATA_W{1'b0}}, 1'b1};
    case (op)
      OP_SUB:  alu = ax - bx;
      OP_INC:  alu = ax + one;
      OP_DEC:  alu = ax - one;
      default: alu = ax + bx;
    endcase
  endfunction

  // Decode
  assign opcode    = ir_p0[OPC_LSB +: OPC_W];
  assign dst       = ir_p0[DST_LSB +: AW];
  assign src_a     = ir_p0[SRCA_LSB +: AW];
  assign src_b     = ir_p0[SRCB_LSB +: AW];
  assign imm       = ir_p0[IMM_LSB +: IMM_W];
  assign imm_pc    = imm[PC_W-1:0];
  assign pc_inc    = pc_q + PC_W'(1);
  assign unused_ir = ^ir_p0[OPC_LSB-1 : DST_LSB+REG_FIELD_W];

  // INC/DEC operate on dst, so port A is steered to it for those opcodes.
  assign rd_a_sel = (opcode == OP_INC || opcode == OP_DEC) ? dst : src_a;

  assign alu_out = alu(opcode, rd_a, rd_b);
  assign res_d   = (opcode == OP_LOAD) ? DATA_W'(imm) : alu_out[DATA_W-1:0];
  assign c_d     = alu_out[DATA_W];

  // Request is held low while reset is asserted, even though the state
  // register already sits in FETCH.
  assign imem.req  = (state_q == ST_FETCH) & rst_n;
  assign imem.addr = pc_q;
  assign fetch_ok  = imem.req & imem.valid;
  assign rf_we     = (state_q == ST_WB);

  seq_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .AW     (AW)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (dst),
    .wdata   (res_p1),
    .raddr_a (rd_a_sel),
    .raddr_b (src_b),
    .raddr_d (dbg_raddr[AW-1:0]),
    .rdata_a (rd_a),
    .rdata_b (rd_b),
    .rdata_d (dbg_rdata)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    setf_d   = setf_p1;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    retire_d = 1'b0;
    ld_ir    = 1'b0;
    ld_res   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (fetch_ok) begin
          ld_ir   = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        ld_res = 1'b1;
        case (opcode)
          OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
            setf_d  = 1'b1;
            state_d = ST_WB;
          end
          OP_LOAD: begin
            setf_d  = 1'b0;
            state_d = ST_WB;
          end
          OP_JMP: begin
            pc_d     = imm_pc;
            state_d  = ST_FETCH;
            retire_d = 1'b1;
          end
          OP_HLT: begin
            state_d  = ST_HALT;
            retire_d = 1'b1;
          end
`ifdef COND_BRANCH_EN
          OP_JZ: begin
            pc_d     = flag_z_q ? imm_pc : pc_inc;
            state_d  = ST_FETCH;
            retire_d = 1'b1;
          end
          OP_JC: begin
            pc_d     = flag_c_q ? imm_pc : pc_inc;
            state_d  = ST_FETCH;
            retire_d = 1'b1;
          end
`else
          OP_JZ, OP_JC: begin
            pc_d     = pc_inc;
            state_d  = ST_FETCH;
            retire_d = 1'b1;
          end
`endif
          default: begin
            pc_d     = pc_inc;
            state_d  = ST_FETCH;
            retire_d = 1'b1;
          end
        endcase
      end
      ST_WB: begin
        if (setf_p1) begin
          flag_z_d = (res_p1 == '0);
          flag_c_d = c_p1;
        end
        pc_d     = pc_inc;
        state_d  = ST_FETCH;
        retire_d = 1'b1;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FETCH;
      pc_q     <= '0;
      setf_p1  <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      retire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      setf_p1  <= setf_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
      retire_q <= retire_d;
    end
  end

  // Fetch -> execute boundary: instruction register
  always_ff @(posedge clk) begin
    if (ld_ir) begin
      ir_p0 <= imem.data;
    end
  end

  // Execute -> write-back boundary: result and carry
  always_ff @(posedge clk) begin
    if (ld_res) begin
      res_p1 <= res_d;
      c_p1   <= c_d;
    end
  end

  assign retire = retire_q;
  assign halted = (state_q == ST_HALT);
  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;

endmodule

// File: tb/tb_seq_core_ctrl.sv
module tb_seq_core_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       retire, halted, flag_z, flag_c;
  logic [1:0] dbg_raddr;
  logic [7:0] dbg_rdata;

  seq_core_ctrl_if #(.PC_W(8)) imem_if ();

  seq_core_ctrl #(
    .DATA_W (8),
    .PC_W   (8),
    .NREG   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem      (imem_if),
    .retire    (retire),
    .halted    (halted),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata)
  );

  always #5 clk = ~clk;

  // Instruction memory with a programmable number of wait cycles per fetch.
  // While valid is low the data bus carries JMP 0xFF, which must never be latched.
  logic [15:0] mem [256];
  int          wait_n = 0;
  int          wcnt   = 0;

  always @(posedge clk) wcnt <= (imem_if.req && !imem_if.valid) ? wcnt + 1 : 0;
  assign imem_if.valid = imem_if.req && (wcnt >= wait_n);
  assign imem_if.data  = imem_if.valid ? mem[imem_if.addr] : 16'hF0FF;

  int         tests = 0;
  int         fails = 0;
  int         ret_n, fetch_n, wait_seen, patch_at;
  int         ret_t [16];
  logic [7:0] ret_v [16];
  logic       ret_z [16];
  logic       ret_c [16];
  logic [7:0] fa    [16];
  logic [1:0] sel   [16];
  logic [7:0] exp_br;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) mem[i] = 16'hC000;
    for (int i = 0; i < 16; i++) sel[i] = 2'd0;
    patch_at = -1;
  endtask

  task automatic load_prog1();
    clear_prog();
    mem[0] = 16'h8005;  // LOAD r0,5
    mem[1] = 16'h8103;  // LOAD r1,3
    mem[2] = 16'h0201;  // ADD r2,r0,r1
    mem[3] = 16'hC000;  // HLT
    sel[2] = 2'd2;
  endtask

  // Reset, release, then run until halted, recording fetches and retires.
  task automatic run(input string tag, input int max_cyc);
    int cyc;
    cyc       = 0;
    ret_n     = 0;
    fetch_n   = 0;
    wait_seen = 0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    while (!halted && cyc < max_cyc) begin
      if (imem_if.req && imem_if.valid && fetch_n < 16) begin
        fa[fetch_n] = imem_if.addr;
        fetch_n++;
      end
      if (imem_if.req && !imem_if.valid) wait_seen++;
      @(negedge clk);
      cyc++;
      if (retire && ret_n < 16) begin
        ret_t[ret_n] = cyc;
        ret_z[ret_n] = flag_z;
        ret_c[ret_n] = flag_c;
        dbg_raddr    = sel[ret_n];
        #1;
        ret_v[ret_n] = dbg_rdata;
        ret_n++;
        if (ret_n == patch_at) mem[0] = 16'hC000;
      end
    end
    chk({tag, "_halted"}, 32'(halted), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    dbg_raddr = 2'd0;
    clear_prog();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req",    32'(imem_if.req),  32'd0);
    chk("rst_retire", 32'(retire),       32'd0);
    chk("rst_halted", 32'(halted),       32'd0);
    chk("rst_flag_z", 32'(flag_z),       32'd0);
    chk("rst_flag_c", 32'(flag_c),       32'd0);
    chk("rst_addr",   32'(imem_if.addr), 32'd0);
    for (int r = 0; r < 4; r++) begin
      dbg_raddr = 2'(r);
      #1;
      chk("rst_reg", 32'(dbg_rdata), 32'd0);
    end

    // LOAD/LOAD/ADD/HLT, zero wait
    wait_n = 0;
    load_prog1();
    run("p1", 200);
    chk("p1_retires",  32'(ret_n),             32'd4);
    chk("p1_r2",       32'(ret_v[2]),          32'h08);
    chk("p1_z",        32'(ret_z[2]),          32'd0);
    chk("p1_c",        32'(ret_c[2]),          32'd0);
    chk("p1_load_lat", 32'(ret_t[0]),          32'd3);
    chk("p1_add_lat",  32'(ret_t[2]-ret_t[1]), 32'd3);
    chk("p1_hlt_lat",  32'(ret_t[3]-ret_t[2]), 32'd2);
    repeat (5) @(negedge clk);
    chk("p1_req_after_halt", 32'(imem_if.req), 32'd0);
    chk("p1_still_halted",   32'(halted),      32'd1);
    chk("p1_no_retire",      32'(retire),      32'd0);

    // INC/DEC wrap and flags
    clear_prog();
    mem[0] = 16'h80FF;  // LOAD r0,0xFF
    mem[1] = 16'hA000;  // INC r0
    mem[2] = 16'hB000;  // DEC r0
    run("p2", 200);
    chk("p2_load_r0", 32'(ret_v[0]), 32'hFF);
    chk("p2_inc_r0",  32'(ret_v[1]), 32'h00);
    chk("p2_inc_z",   32'(ret_z[1]), 32'd1);
    chk("p2_inc_c",   32'(ret_c[1]), 32'd1);
    chk("p2_dec_r0",  32'(ret_v[2]), 32'hFF);
    chk("p2_dec_z",   32'(ret_z[2]), 32'd0);
    chk("p2_dec_c",   32'(ret_c[2]), 32'd1);

    // JMP
    clear_prog();
    mem[0]    = 16'hF010;  // JMP 0x10
    mem[8'h1] = 16'h8055;  // must be skipped
    run("p3", 200);
    chk("p3_fetches", 32'(fetch_n),  32'd2);
    chk("p3_fetch0",  32'(fa[0]),    32'h00);
    chk("p3_fetch1",  32'(fa[1]),    32'h10);
    chk("p3_jmp_lat", 32'(ret_t[0]), 32'd2);

    // Program 1 with 3 wait cycles on every fetch
    wait_n = 3;
    load_prog1();
    run("p4", 400);
    chk("p4_r2",      32'(ret_v[2]),          32'h08);
    chk("p4_z",       32'(ret_z[2]),          32'd0);
    chk("p4_c",       32'(ret_c[2]),          32'd0);
    chk("p4_add_lat", 32'(ret_t[2]-ret_t[1]), 32'd6);
    chk("p4_hlt_t",   32'(ret_t[3]),          32'd23);
    chk("p4_waits",   32'(wait_seen),         32'd12);
    wait_n = 0;

    // Reset during the write-back of ADD r2
    load_prog1();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    dbg_raddr = 2'd0;
    #1;
    chk("p5_r0_before", 32'(dbg_rdata), 32'h05);
    rst_n = 1'b0;
    #1;
    chk("p5_req_in_rst", 32'(imem_if.req), 32'd0);
    @(negedge clk);
    dbg_raddr = 2'd2;
    #1;
    chk("p5_r2", 32'(dbg_rdata), 32'h00);
    dbg_raddr = 2'd0;
    #1;
    chk("p5_r0",     32'(dbg_rdata),    32'h00);
    chk("p5_pc",     32'(imem_if.addr), 32'h00);
    chk("p5_retire", 32'(retire),       32'd0);
    rst_n = 1'b1;
    #1;
    chk("p5_fetch_state", 32'(imem_if.req), 32'd1);
    chk("p5_halted",      32'(halted),      32'd0);

    // Conditional branch (JZ) or NOP, depending on build
    clear_prog();
    mem[0] = 16'h1000;  // SUB r0,r0,r0
    mem[1] = 16'hD020;  // JZ 0x20
`ifdef COND_BRANCH_EN
    exp_br = 8'h20;
`else
    exp_br = 8'h02;
`endif
    run("p6", 200);
    chk("p6_sub_z",   32'(ret_z[0]),          32'd1);
    chk("p6_sub_c",   32'(ret_c[0]),          32'd0);
    chk("p6_br_addr", 32'(fa[2]),             32'(exp_br));
    chk("p6_br_lat",  32'(ret_t[1]-ret_t[0]), 32'd2);

    // ADD carry, operand aliasing, LOAD keeping flags, SUB borrow
    clear_prog();
    mem[0] = 16'h8180; sel[0] = 2'd1;  // LOAD r1,0x80
    mem[1] = 16'h0111; sel[1] = 2'd1;  // ADD r1,r1,r1
    mem[2] = 16'h8203; sel[2] = 2'd2;  // LOAD r2,3
    mem[3] = 16'h1312; sel[3] = 2'd3;  // SUB r3,r1,r2
    mem[4] = 16'h1332; sel[4] = 2'd3;  // SUB r3,r3,r2
    run("p7", 200);
    chk("p7_add_r1",   32'(ret_v[1]), 32'h00);
    chk("p7_add_z",    32'(ret_z[1]), 32'd1);
    chk("p7_add_c",    32'(ret_c[1]), 32'd1);
    chk("p7_load_z",   32'(ret_z[2]), 32'd1);
    chk("p7_load_c",   32'(ret_c[2]), 32'd1);
    chk("p7_sub_r3",   32'(ret_v[3]), 32'hFD);
    chk("p7_sub_c",    32'(ret_c[3]), 32'd1);
    chk("p7_sub_z",    32'(ret_z[3]), 32'd0);
    chk("p7_sub2_r3",  32'(ret_v[4]), 32'hFA);
    chk("p7_sub2_c",   32'(ret_c[4]), 32'd0);

    // PC wrap 0xFF -> 0x00, NOP latency
    clear_prog();
    mem[0]     = 16'hF0FE;  // JMP 0xFE
    mem[8'hFE] = 16'h835A;  // LOAD r3,0x5A
    mem[8'hFF] = 16'h7000;  // NOP
    sel[1]     = 2'd3;
    patch_at   = 1;         // after JMP retires, address 0 becomes HLT
    run("p8", 200);
    chk("p8_fetch3",  32'(fa[3]),             32'h00);
    chk("p8_r3",      32'(ret_v[1]),          32'h5A);
    chk("p8_nop_lat", 32'(ret_t[2]-ret_t[1]), 32'd2);
    chk("p8_retires", 32'(ret_n),             32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
